// File: rtl/bp_io_to_mc_bridge.sv
// Bridges BlackParrot uncached I/O commands onto bsg_manycore request packets.
// One command is in flight at a time; 8-byte ops go out as two 32-bit packets.
module bp_io_to_mc_bridge #(
  parameter int unsigned paddr_width_p     = 40,
  parameter int unsigned mc_addr_width_p   = 28,
  parameter int unsigned mc_x_cord_width_p = 4,
  parameter int unsigned mc_y_cord_width_p = 4,
  parameter int unsigned mc_data_width_p   = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,

  input  logic                         io_cmd_v_i,
  output logic                         io_cmd_ready_o,
  input  logic                         io_cmd_we_i,
  input  logic [1:0]                   io_cmd_size_i,
  input  logic [paddr_width_p-1:0]     io_cmd_addr_i,
  input  logic [63:0]                  io_cmd_data_i,

  output logic                         io_resp_v_o,
  input  logic                         io_resp_yumi_i,
  output logic                         io_resp_we_o,
  output logic [1:0]                   io_resp_size_o,
  output logic [paddr_width_p-1:0]     io_resp_addr_o,
  output logic [63:0]                  io_resp_data_o,

  output logic                         out_v_o,
  input  logic                         out_ready_i,
  output logic                         out_we_o,
  output logic [mc_addr_width_p-1:0]   out_addr_o,
  output logic [mc_data_width_p-1:0]   out_data_o,
  output logic [3:0]                   out_mask_o,
  output logic [mc_x_cord_width_p-1:0] out_x_o,
  output logic [mc_y_cord_width_p-1:0] out_y_o,

  input  logic                         returned_v_i,
  input  logic [mc_data_width_p-1:0]   returned_data_i,
  output logic                         returned_yumi_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_LO,
    S_SEND_HI,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                       r_state;
  logic                         r_we;
  logic [1:0]                   r_size;
  logic [paddr_width_p-1:0]     r_addr;
  logic [63:0]                  r_data;
  logic [mc_data_width_p-1:0]   r_lo;
  logic [mc_data_width_p-1:0]   r_hi;
  logic                         r_rcnt;

  logic                         w_is8;
  logic                         w_ret_take;
  logic [mc_addr_width_p-1:0]   w_word;

  assign w_is8      = (r_size == 2'd3);
  // The LO response may come back while the HI packet is still waiting to go out.
  assign w_ret_take = returned_v_i && ((r_state == S_SEND_HI) || (r_state == S_WAIT));
  assign w_word     = r_addr[2 +: mc_addr_width_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rcnt  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io_cmd_v_i) begin
            r_we    <= io_cmd_we_i;
            r_size  <= io_cmd_size_i;
            r_addr  <= io_cmd_addr_i;
            r_data  <= io_cmd_data_i;
            r_rcnt  <= 1'b0;
            r_state <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (out_ready_i) r_state <= w_is8 ? S_SEND_HI : S_WAIT;
        end
        S_SEND_HI: begin
          if (w_ret_take) begin
            r_lo   <= returned_data_i;
            r_rcnt <= 1'b1;
          end
          if (out_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (returned_v_i) begin
            if (r_rcnt) r_hi <= returned_data_i;
            else        r_lo <= returned_data_i;
            if (!w_is8 || r_rcnt) r_state <= S_RESP;
            else                  r_rcnt  <= 1'b1;
          end
        end
        S_RESP: begin
          if (io_resp_yumi_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_cmd_ready_o  = (r_state == S_IDLE);
  assign io_resp_v_o     = (r_state == S_RESP);
  assign out_v_o         = (r_state == S_SEND_LO) || (r_state == S_SEND_HI);
  assign returned_yumi_o = w_ret_take;

  assign io_resp_we_o    = r_we;
  assign io_resp_size_o  = r_size;
  assign io_resp_addr_o  = r_addr;

  assign out_we_o   = r_we;
  assign out_addr_o = w_word + mc_addr_width_p'(r_state == S_SEND_HI);
  assign out_x_o    = r_addr[2+mc_addr_width_p +: mc_x_cord_width_p];
  assign out_y_o    = r_addr[2+mc_addr_width_p+mc_x_cord_width_p +: mc_y_cord_width_p];

  always_comb begin
    out_mask_o = 4'hF;
    out_data_o = r_data[31:0];
    case (r_size)
      2'd0: begin
        out_mask_o = 4'b0001 << r_addr[1:0];
        out_data_o = {4{r_data[7:0]}};
      end
      2'd1: begin
        out_mask_o = r_addr[1] ? 4'b1100 : 4'b0011;
        out_data_o = {2{r_data[15:0]}};
      end
      2'd3: begin
        out_data_o = (r_state == S_SEND_HI) ? r_data[63:32] : r_data[31:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    io_resp_data_o = '0;
    if (!r_we) begin
      case (r_size)
        2'd0:    io_resp_data_o[7:0]  = r_lo[{r_addr[1:0], 3'b000} +: 8];
        2'd1:    io_resp_data_o[15:0] = r_lo[{r_addr[1], 4'b0000} +: 16];
        2'd2:    io_resp_data_o[31:0] = r_lo;
        default: io_resp_data_o       = {r_hi, r_lo};
      endcase
    end
  end

endmodule

// File: tb/tb_bp_io_to_mc_bridge.sv
// Scoreboard bench for bp_io_to_mc_bridge: directed cases plus randomized commands
// checked against an arithmetic reference model of the packet/response rules.
module tb_bp_io_to_mc_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_v, cmd_ready, cmd_we;
  logic [1:0]  cmd_size;
  logic [39:0] cmd_addr;
  logic [63:0] cmd_data;
  logic        resp_v, resp_yumi, resp_we;
  logic [1:0]  resp_size;
  logic [39:0] resp_addr;
  logic [63:0] resp_data;
  logic        out_v, out_ready, out_we;
  logic [27:0] out_addr;
  logic [31:0] out_data;
  logic [3:0]  out_mask, out_x, out_y;
  logic        ret_v;
  logic [31:0] ret_data;
  logic        ret_yumi;

  bp_io_to_mc_bridge #(
    .paddr_width_p(40), .mc_addr_width_p(28), .mc_x_cord_width_p(4),
    .mc_y_cord_width_p(4), .mc_data_width_p(32)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .io_cmd_v_i(cmd_v), .io_cmd_ready_o(cmd_ready), .io_cmd_we_i(cmd_we),
    .io_cmd_size_i(cmd_size), .io_cmd_addr_i(cmd_addr), .io_cmd_data_i(cmd_data),
    .io_resp_v_o(resp_v), .io_resp_yumi_i(resp_yumi), .io_resp_we_o(resp_we),
    .io_resp_size_o(resp_size), .io_resp_addr_o(resp_addr), .io_resp_data_o(resp_data),
    .out_v_o(out_v), .out_ready_i(out_ready), .out_we_o(out_we), .out_addr_o(out_addr),
    .out_data_o(out_data), .out_mask_o(out_mask), .out_x_o(out_x), .out_y_o(out_y),
    .returned_v_i(ret_v), .returned_data_i(ret_data), .returned_yumi_o(ret_yumi)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        we;
    bit [27:0] addr;
    bit [31:0] data;
    bit [3:0]  mask;
    bit [3:0]  x;
    bit [3:0]  y;
    bit [31:0] rdata;
  } pkt_t;

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit [39:0] addr;
    bit [63:0] data;
  } rsp_t;

  pkt_t        exp_pkt[$];
  rsp_t        exp_rsp[$];
  logic [31:0] ret_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int issued_cnt = 0;
  int resp_cnt   = 0;
  int accept_cyc = 0;
  int stall_cnt  = 0;
  int yumi_delay = 0;
  bit rand_mode  = 1'b0;
  bit hold_ret   = 1'b0;
  bit lat_check  = 1'b0;
  bit taken      = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [39:0] mk_addr(input int unsigned x, input int unsigned y,
                                          input int unsigned word, input int unsigned off);
    logic [63:0] a;
    a = (64'(y) << 34) | (64'(x) << 30) | (64'(word) << 2) | 64'(off);
    return a[39:0];
  endfunction

  // Reference model: packets and response derived from the address map and lane rules.
  task automatic push_expect(input bit we, input bit [1:0] size, input bit [39:0] addr,
                             input bit [63:0] d, input bit [31:0] rlo, input bit [31:0] rhi);
    pkt_t        p;
    rsp_t        r;
    longint unsigned a, word, off;
    a    = 64'(addr);
    word = (a >> 2) % (64'd1 << 28);
    off  = a % 4;
    p.we = we;
    p.addr = 28'(word);
    p.x = 4'((a >> 30) % 16);
    p.y = 4'((a >> 34) % 16);
    p.rdata = rlo;
    case (size)
      2'd0: begin p.mask = 4'(1 << off);           p.data = 32'((d % 256) * 32'h0101_0101); end
      2'd1: begin p.mask = 4'(3 << (2 * (off / 2))); p.data = 32'((d % 65536) * 32'h0001_0001); end
      default: begin p.mask = 4'hF;                 p.data = 32'(d % (64'd1 << 32)); end
    endcase
    exp_pkt.push_back(p);
    if (size == 2'd3) begin
      p.addr  = 28'((word + 1) % (64'd1 << 28));
      p.data  = 32'(d >> 32);
      p.rdata = rhi;
      exp_pkt.push_back(p);
    end
    r.we = we;
    r.size = size;
    r.addr = addr;
    if (we) r.data = 64'd0;
    else case (size)
      2'd0:    r.data = (64'(rlo) >> (8 * off)) % 256;
      2'd1:    r.data = (64'(rlo) >> (16 * (off / 2))) % 65536;
      2'd2:    r.data = 64'(rlo);
      default: r.data = (64'(rhi) << 32) + 64'(rlo);
    endcase
    exp_rsp.push_back(r);
  endtask

  task automatic issue(input bit we, input bit [1:0] size, input bit [39:0] addr,
                       input bit [63:0] d, input bit [31:0] rlo, input bit [31:0] rhi);
    int n;
    @(posedge clk); #1;
    cmd_v = 1'b1; cmd_we = we; cmd_size = size; cmd_addr = addr; cmd_data = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 500) begin
        fail_now("cmd accept");
        cmd_v = 1'b0;
        return;
      end
    end
    push_expect(we, size, addr, d, rlo, rhi);
    accept_cyc = cyc;
    issued_cnt++;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    cmd_data = {$urandom, $urandom};
    cmd_addr = {8'h5A, $urandom};
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (resp_cnt != issued_cnt) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        fail_now("completion");
        return;
      end
    end
  endtask

  // Endpoint ready: directed stalls, otherwise always ready or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (rand_mode) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = 1'b1;
    end
  end

  // Packet monitor: pops the expected packet on each transfer, checks held payloads.
  initial begin
    logic [72:0] saved, cur, expv;
    bit held;
    pkt_t e;
    held = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 1'b0;
      else if (out_v) begin
        cur = {out_we, out_addr, out_data, out_mask, out_x, out_y};
        if (held) check("pkt hold", 128'(cur), 128'(saved));
        if (out_ready) begin
          held = 1'b0;
          if (exp_pkt.size() == 0) check("unexpected pkt", 128'(cur), 128'(0));
          else begin
            e = exp_pkt.pop_front();
            expv = {e.we, e.addr, (e.we ? e.data : 32'd0), e.mask, e.x, e.y};
            check("pkt", 128'({out_we, out_addr, (e.we ? out_data : 32'd0), out_mask, out_x, out_y}),
                  128'(expv));
            ret_q.push_back(e.rdata);
          end
        end else begin
          held = 1'b1;
          saved = cur;
        end
      end else if (held) begin
        check("pkt retract", 128'(out_v), 128'(1));
        held = 1'b0;
      end
    end
  end

  // Manycore endpoint: returns responses in issue order, holds valid until consumed.
  initial begin
    ret_v = 1'b0;
    ret_data = '0;
    forever begin
      @(posedge clk); #1;
      if (taken) begin
        ret_v = 1'b0;
        taken = 1'b0;
      end
      if (!ret_v && ret_q.size() > 0 && !hold_ret && (!rand_mode || $urandom_range(0, 2) == 0)) begin
        ret_v = 1'b1;
        ret_data = ret_q[0];
      end
      @(negedge clk);
      if (ret_yumi) begin
        if (!ret_v) check("yumi without v", 128'(ret_yumi), 128'(0));
        else begin
          void'(ret_q.pop_front());
          taken = 1'b1;
        end
      end
    end
  end

  // Response monitor: compares each response, checks stability while yumi is withheld.
  initial begin
    rsp_t e;
    logic [106:0] cap;
    int d;
    resp_yumi = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && resp_v) begin
        cap = {resp_we, resp_size, resp_addr, resp_data};
        if (exp_rsp.size() == 0) check("unexpected resp", 128'(cap), 128'(0));
        else begin
          e = exp_rsp.pop_front();
          check("resp", 128'(cap), 128'({e.we, e.size, e.addr, e.data}));
        end
        if (lat_check) begin
          check("latency", 128'(cyc - accept_cyc), 128'(3));
          lat_check = 1'b0;
        end
        check("ready in resp", 128'(cmd_ready), 128'(0));
        d = rand_mode ? int'($urandom_range(0, 3)) : yumi_delay;
        for (int i = 0; i < d; i++) begin
          @(negedge clk);
          check("resp hold", 128'({resp_v, cmd_ready, resp_we, resp_size, resp_addr, resp_data}),
                128'({2'b10, cap}));
        end
        @(posedge clk); #1;
        resp_yumi = 1'b1;
        @(posedge clk); #1;
        resp_yumi = 1'b0;
        @(negedge clk);
        check("post yumi", 128'({cmd_ready, resp_v}), 128'({1'b1, 1'b0}));
        resp_cnt++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r1, r2, r3, r4, r5, r6;
    logic [39:0] a;
    int n;
    rst_n = 1'b0;
    cmd_v = 1'b0; cmd_we = 1'b0; cmd_size = '0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset state", 128'({cmd_ready, resp_v, out_v, ret_yumi}), 128'(4'b1000));
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);

    lat_check = 1'b1;
    issue(1'b1, 2'd2, mk_addr(1, 2, 'h10, 0), 64'h0123_4567_DEAD_BEEF, $urandom, $urandom);
    wait_done();
    issue(1'b0, 2'd0, mk_addr(5, 3, 'h0ABCDE0, 3), {$urandom, $urandom}, 32'hAABB_CCDD, $urandom);
    wait_done();
    issue(1'b1, 2'd3, mk_addr(2, 1, 'h0000100, 0), 64'h1122_3344_5566_7788, $urandom, $urandom);
    wait_done();
    stall_cnt = 6;
    issue(1'b0, 2'd3, mk_addr(7, 9, 'h0123456, 5), {$urandom, $urandom}, 32'h0BAD_F00D, 32'hCAFE_1234);
    wait_done();
    issue(1'b0, 2'd3, mk_addr(3, 3, 'hFFFFFFF, 0), {$urandom, $urandom}, 32'h1357_9BDF, 32'h2468_ACE0);
    wait_done();
    issue(1'b1, 2'd1, mk_addr(1, 1, 'h20, 3), 64'h0000_0000_0000_ABCD, $urandom, $urandom);
    wait_done();
    issue(1'b0, 2'd1, mk_addr(1, 1, 'h21, 2), {$urandom, $urandom}, 32'h8765_4321, $urandom);
    wait_done();
    yumi_delay = 10;
    issue(1'b0, 2'd2, mk_addr(4, 6, 'h0555555, 0), {$urandom, $urandom}, 32'hFEED_FACE, $urandom);
    wait_done();
    yumi_delay = 0;

    // Reset asserted while the bridge waits for a response.
    hold_ret = 1'b1;
    issue(1'b0, 2'd2, mk_addr(8, 8, 'h0000042, 0), {$urandom, $urandom}, $urandom, $urandom);
    n = 0;
    while (ret_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ret_q.size() == 0) fail_now("reach wait");
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    ret_v = 1'b1;
    #1;
    check("reset in wait", 128'({cmd_ready, resp_v, out_v, ret_yumi}), 128'(4'b1000));
    ret_v = 1'b0;
    taken = 1'b0;
    ret_q.delete();
    exp_pkt.delete();
    exp_rsp.delete();
    issued_cnt = resp_cnt;
    hold_ret = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b1, 2'd0, mk_addr(2, 2, 'h0000077, 1), 64'h0000_0000_0000_005C, $urandom, $urandom);
    wait_done();

    rand_mode = 1'b1;
    repeat (80) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom; r4 = $urandom; r5 = $urandom; r6 = $urandom;
      a = {r1[7:0], r2};
      if (r3[2:0] == 3'd0) a[29:2] = '1;
      issue(r3[3], r3[5:4], a, {r4, r5}, r6, $urandom);
    end
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
